// File: rtl/pic_rw_sequencer_pkg.sv
// pic_rw_sequencer_pkg: shared encodings for the PIC read/write sequencer
// Holds the cw_flag word-type codes, the read_sel register codes and the
// sequencer state enum used by pic_rw_sequencer.
package pic_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ICW2,
        ST_WAIT_ICW3,
        ST_WAIT_ICW4,
        ST_READY
    } state_t;

    localparam logic [2:0] FLAG_ICW1 = 3'd0;
    localparam logic [2:0] FLAG_ICW2 = 3'd1;
    localparam logic [2:0] FLAG_ICW3 = 3'd2;
    localparam logic [2:0] FLAG_ICW4 = 3'd3;
    localparam logic [2:0] FLAG_OCW1 = 3'd4;
    localparam logic [2:0] FLAG_OCW2 = 3'd5;
    localparam logic [2:0] FLAG_OCW3 = 3'd6;
    localparam logic [2:0] FLAG_NONE = 3'd7;

    localparam logic [2:0] RSEL_NONE = 3'b000;
    localparam logic [2:0] RSEL_IRR  = 3'b001;
    localparam logic [2:0] RSEL_ISR  = 3'b101;
    localparam logic [2:0] RSEL_IMR  = 3'b011;
endpackage

// File: rtl/pic_rw_sequencer_strobe_sync.sv
// pic_strobe_sync: optional strobe synchronizer plus wr_n rising-edge commit detector
// Config macro: PIC_RW_SYNC_EN -- when defined, cs_n/rd_n/wr_n pass a two-flop
// synchronizer (reset to 1) and a0/data_in are delayed to stay aligned.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cs_n, rd_n, wr_n, a0, data_in  raw CPU bus inputs
//   cs_s, rd_s, wr_s, a0_s, data_s sampled (optionally synchronized) copies
//   commit                      high on the sample where wr_n rises after a
//                               qualified low sample (cs_n=0, rd_n=1)
module pic_strobe_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] data_in,
    output logic       cs_s,
    output logic       rd_s,
    output logic       wr_s,
    output logic       a0_s,
    output logic [7:0] data_s,
    output logic       commit
);
    logic arm_ok;
    logic armed;
    logic low_q;
    logic ok_q;
`ifdef PIC_RW_SYNC_EN
    logic [1:0] cs_f;
    logic [1:0] rd_f;
    logic [1:0] wr_f;
    logic [1:0] a0_f;
    logic [7:0] d_f [2];
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_f   <= 2'b11;
            rd_f   <= 2'b11;
            wr_f   <= 2'b11;
            a0_f   <= 2'b00;
            d_f[0] <= 8'h00;
            d_f[1] <= 8'h00;
        end else begin
            cs_f   <= {cs_f[0], cs_n};
            rd_f   <= {rd_f[0], rd_n};
            wr_f   <= {wr_f[0], wr_n};
            a0_f   <= {a0_f[0], a0};
            d_f[0] <= data_in;
            d_f[1] <= d_f[0];
        end
    end
    assign cs_s   = cs_f[1];
    assign rd_s   = rd_f[1];
    assign wr_s   = wr_f[1];
    assign a0_s   = a0_f[1];
    assign data_s = d_f[1];
    // Arm only once the whole chain reads high, so a write straddling reset
    // cannot surface as a fresh low pulse through the reset-to-1 flops.
    assign arm_ok = wr_n & (&wr_f);
`else
    assign cs_s   = cs_n;
    assign rd_s   = rd_n;
    assign wr_s   = wr_n;
    assign a0_s   = a0;
    assign data_s = data_in;
    assign arm_ok = wr_n;
`endif

    // armed blocks any write already in progress at reset from committing:
    // a wr_n low phase only counts once wr_n has been seen high after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            low_q <= 1'b0;
            ok_q  <= 1'b0;
        end else begin
            armed <= armed | arm_ok;
            low_q <= armed & ~wr_s;
            ok_q  <= ~cs_s & rd_s;
        end
    end

    assign commit = wr_s & low_q & ok_q;
endmodule

// File: rtl/pic_rw_sequencer.sv
// pic_rw_sequencer: 8259-style ICW/OCW write sequencer and read-register select
// Config macro: PIC_RW_SYNC_EN (see pic_strobe_sync) adds a strobe synchronizer.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cs_n, rd_n, wr_n    low-active chip select / read / write strobes
//   a0, data_in         address bit and CPU data bus
//   cw_data, cw_flag    captured control word and its type (7 = none)
//   cw_valid            one-cycle commit pulse
//   read_sel, data_oe   selected read register and bus drive enable
//   init_done           high while the ICW sequence is complete (READY)
module pic_rw_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] data_in,
    output logic [7:0] cw_data,
    output logic [2:0] cw_flag,
    output logic       cw_valid,
    output logic [2:0] read_sel,
    output logic       data_oe,
    output logic       init_done
);
    logic       cs_s, rd_s, wr_s, a0_s, commit;
    logic [7:0] data_s;
    logic       la0;
    logic [7:0] ldata;
    logic       sngl, ic4;
    logic [2:0] rreg;
    state_t     state, state_d;
    logic [2:0] flag_d;
    logic       rd_act;
    logic [2:0] read_sel_d;

    pic_strobe_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .cs_n    (cs_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .a0      (a0),
        .data_in (data_in),
        .cs_s    (cs_s),
        .rd_s    (rd_s),
        .wr_s    (wr_s),
        .a0_s    (a0_s),
        .data_s  (data_s),
        .commit  (commit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            la0   <= 1'b0;
            ldata <= 8'h00;
        end else if (~wr_s & ~cs_s & rd_s) begin
            la0   <= a0_s;
            ldata <= data_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            sngl     <= 1'b0;
            ic4      <= 1'b0;
            rreg     <= RSEL_IRR;
            cw_valid <= 1'b0;
            cw_flag  <= FLAG_NONE;
            cw_data  <= 8'h00;
            read_sel <= RSEL_NONE;
            data_oe  <= 1'b0;
        end else begin
            state    <= state_d;
            cw_valid <= flag_d != FLAG_NONE;
            cw_flag  <= flag_d;
            read_sel <= read_sel_d;
            data_oe  <= rd_act;
            if (flag_d != FLAG_NONE) cw_data <= ldata;
            if (flag_d == FLAG_ICW1) begin
                sngl <= ldata[1];
                ic4  <= ldata[0];
                rreg <= RSEL_IRR;
            end
            if (flag_d == FLAG_OCW3 && ldata[1]) rreg <= ldata[0] ? RSEL_ISR : RSEL_IRR;
        end
    end

    // ICW1 (a0=0, bit4=1) restarts initialization from any state.
    always_comb begin
        state_d = state;
        flag_d  = FLAG_NONE;
        if (commit) begin
            if (~la0 & ldata[4]) begin
                flag_d  = FLAG_ICW1;
                state_d = ST_WAIT_ICW2;
            end else begin
                case (state)
                    ST_WAIT_ICW2: if (la0) begin
                        flag_d  = FLAG_ICW2;
                        state_d = ~sngl ? ST_WAIT_ICW3 : ic4 ? ST_WAIT_ICW4 : ST_READY;
                    end
                    ST_WAIT_ICW3: if (la0) begin
                        flag_d  = FLAG_ICW3;
                        state_d = ic4 ? ST_WAIT_ICW4 : ST_READY;
                    end
                    ST_WAIT_ICW4: if (la0) begin
                        flag_d  = FLAG_ICW4;
                        state_d = ST_READY;
                    end
                    ST_READY:
                        flag_d = la0 ? FLAG_OCW1 :
                                 (ldata[4:3] == 2'b00) ? FLAG_OCW2 :
                                 (ldata[4:3] == 2'b01) ? FLAG_OCW3 : FLAG_NONE;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_act     = ~cs_s & ~rd_s & wr_s & (state == ST_READY);
        read_sel_d = rd_act ? (a0_s ? RSEL_IMR : rreg) : RSEL_NONE;
    end

    assign init_done = state == ST_READY;
endmodule

// File: tb/tb_pic_rw_sequencer.sv
// tb_pic_rw_sequencer: directed self-checking bench for pic_rw_sequencer (default build)
module tb_pic_rw_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] cw_data;
    logic [2:0] cw_flag;
    logic       cw_valid;
    logic [2:0] read_sel;
    logic       data_oe;
    logic       init_done;
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    pic_rw_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .a0        (a0),
        .data_in   (data_in),
        .cw_data   (cw_data),
        .cw_flag   (cw_flag),
        .cw_valid  (cw_valid),
        .read_sel  (read_sel),
        .data_oe   (data_oe),
        .init_done (init_done)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    task automatic outs(input string tag, input logic v, input logic [2:0] f,
                        input logic [7:0] d, input logic i);
        chk({tag, ".valid"}, 8'(cw_valid), 8'(v));
        chk({tag, ".flag"}, 8'(cw_flag), 8'(f));
        chk({tag, ".data"}, cw_data, d);
        chk({tag, ".init"}, 8'(init_done), 8'(i));
    endtask

    // One write cycle; returns #1 after the commit edge (wr_n rise sample).
    task automatic wr(input logic a, input logic [7:0] d, input logic c, input logic r);
        @(negedge clk);
        cs_n = c; rd_n = r; a0 = a; data_in = d; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic settle(input string tag, input logic [7:0] d, input logic i);
        @(posedge clk); #1;
        outs(tag, 1'b0, 3'd7, d, i);
    endtask

    task automatic rd(input string tag, input logic a, input logic [2:0] sel, input logic oe);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; a0 = a;
        @(posedge clk); #1;
        chk({tag, ".sel"}, 8'(read_sel), 8'(sel));
        chk({tag, ".oe"}, 8'(data_oe), 8'(oe));
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".sel_off"}, 8'(read_sel), 8'd0);
        chk({tag, ".oe_off"}, 8'(data_oe), 8'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        outs("rst", 1'b0, 3'd7, 8'h00, 1'b0);
        chk("rst.sel", 8'(read_sel), 8'd0);
        chk("rst.oe", 8'(data_oe), 8'd0);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(posedge clk);

        wr(1'b0, 8'h13, 1'b0, 1'b1); outs("s1.icw1", 1'b1, 3'd0, 8'h13, 1'b0);
        settle("s1.icw1.end", 8'h13, 1'b0);
        wr(1'b1, 8'h20, 1'b0, 1'b1); outs("s1.icw2", 1'b1, 3'd1, 8'h20, 1'b0);
        wr(1'b1, 8'h01, 1'b0, 1'b1); outs("s1.icw4", 1'b1, 3'd3, 8'h01, 1'b1);
        settle("s1.ready", 8'h01, 1'b1);

        wr(1'b0, 8'h11, 1'b0, 1'b1); outs("s2.icw1", 1'b1, 3'd0, 8'h11, 1'b0);
        wr(1'b1, 8'h08, 1'b0, 1'b1); outs("s2.icw2", 1'b1, 3'd1, 8'h08, 1'b0);
        wr(1'b1, 8'h04, 1'b0, 1'b1); outs("s2.icw3", 1'b1, 3'd2, 8'h04, 1'b0);
        wr(1'b1, 8'h1D, 1'b0, 1'b1); outs("s2.icw4", 1'b1, 3'd3, 8'h1D, 1'b1);
        wr(1'b1, 8'hFE, 1'b0, 1'b1); outs("s2.ocw1", 1'b1, 3'd4, 8'hFE, 1'b1);

        wr(1'b0, 8'h20, 1'b0, 1'b1); outs("s3.ocw2", 1'b1, 3'd5, 8'h20, 1'b1);
        wr(1'b0, 8'h0B, 1'b0, 1'b1); outs("s3.ocw3", 1'b1, 3'd6, 8'h0B, 1'b1);
        rd("s3.rd_isr", 1'b0, 3'b101, 1'b1);
        rd("s3.rd_imr", 1'b1, 3'b011, 1'b1);
        wr(1'b0, 8'h08, 1'b0, 1'b1); outs("s3.ocw3_norr", 1'b1, 3'd6, 8'h08, 1'b1);
        rd("s3.rd_keep", 1'b0, 3'b101, 1'b1);
        wr(1'b0, 8'h0A, 1'b0, 1'b1); outs("s3.ocw3_irr", 1'b1, 3'd6, 8'h0A, 1'b1);
        rd("s3.rd_irr", 1'b0, 3'b001, 1'b1);

        wr(1'b0, 8'h13, 1'b0, 1'b1); outs("s4.icw1a", 1'b1, 3'd0, 8'h13, 1'b0);
        wr(1'b0, 8'h12, 1'b0, 1'b1); outs("s4.icw1b", 1'b1, 3'd0, 8'h12, 1'b0);
        rd("s4.rd_notready", 1'b0, 3'b000, 1'b0);
        wr(1'b0, 8'h05, 1'b0, 1'b1); outs("s4.ign_a0", 1'b0, 3'd7, 8'h12, 1'b0);
        wr(1'b1, 8'h40, 1'b0, 1'b1); outs("s4.icw2", 1'b1, 3'd1, 8'h40, 1'b1);

        wr(1'b1, 8'h55, 1'b1, 1'b1); outs("s5.cs_hi", 1'b0, 3'd7, 8'h40, 1'b1);
        wr(1'b1, 8'h66, 1'b0, 1'b0); outs("s5.rd_lo", 1'b0, 3'd7, 8'h40, 1'b1);
        wr(1'b1, 8'h77, 1'b0, 1'b1); outs("s5.ocw1", 1'b1, 3'd4, 8'h77, 1'b1);

        @(negedge clk);
        cs_n = 1'b0; a0 = 1'b0; data_in = 8'h13; wr_n = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); wr_n = 1'b1; cs_n = 1'b1;
        @(posedge clk); #1;
        outs("s6.rst_wr", 1'b0, 3'd7, 8'h00, 1'b0);
        settle("s6.after", 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
